// File: rtl/bp_update_queue_if.sv
// Branch-predictor update bus: the producer-side push fields and the head-of-queue
// fields offered to FetchStage1, with the predictor's ready back-pressure.
interface bp_update_queue_if #(
  parameter int PC_W   = 32,
  parameter int TYPE_W = 2
);
  logic [PC_W-1:0]   updatePC_i;
  logic [PC_W-1:0]   updateNPC_i;
  logic [TYPE_W-1:0] updateCtrlType_i;
  logic              updateDir_i;
  logic [1:0]        updateCounter_i;
  logic              updateEn_i;

  logic [PC_W-1:0]   updatePC_o;
  logic [PC_W-1:0]   updateNPC_o;
  logic [TYPE_W-1:0] updateCtrlType_o;
  logic              updateDir_o;
  logic [1:0]        updateCounter_o;
  logic              updateEn_o;
  logic              updateReady_i;

  // The queue itself sits on the slave side.
  modport slave (
    input  updatePC_i, updateNPC_i, updateCtrlType_i, updateDir_i, updateCounter_i, updateEn_i,
    input  updateReady_i,
    output updatePC_o, updateNPC_o, updateCtrlType_o, updateDir_o, updateCounter_o, updateEn_o
  );

  modport master (
    output updatePC_i, updateNPC_i, updateCtrlType_i, updateDir_i, updateCounter_i, updateEn_i,
    output updateReady_i,
    input  updatePC_o, updateNPC_o, updateCtrlType_o, updateDir_o, updateCounter_o, updateEn_o
  );
endinterface

// File: rtl/bp_update_queue.sv
// Circular queue of branch-predictor updates in front of FS1's BTB/BPB update port.
// Never stalls the producer: each push is written, merged into the youngest entry, or dropped.
module bp_update_queue #(
  parameter int DEPTH       = 4,
  parameter int PC_W        = 32,
  parameter int TYPE_W      = 2,
  parameter int COALESCE_EN = 1,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  bp_update_queue_if.slave           upd,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       coalesced_o,
  output logic                       drop_o,
  output logic [DROP_CNT_W-1:0]      dropCount_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   npc;
    logic [TYPE_W-1:0] ctrlType;
    logic              dir;
    logic [1:0]        counter;
  } entry_t;

  logic [PTR_W-1:0]      headReg, tailReg, youngIdx;
  logic [CNT_W-1:0]      countReg, countNext;
  logic                  coalescedReg, dropReg;
  logic [DROP_CNT_W-1:0] dropCountReg;
  entry_t                entryArr [DEPTH];
  entry_t                headEntry, youngEntry;

  logic pop, pushLive, coalesceHit, doWrite, doDrop;

  assign youngIdx   = tailReg - PTR_W'(1);
  assign headEntry  = entryArr[headReg];
  assign youngEntry = entryArr[youngIdx];

  assign pop      = (countReg != '0) && upd.updateReady_i;
  assign pushLive = upd.updateEn_i && !flush_i;

  // The youngest entry is off-limits when it is also the head leaving this cycle.
  assign coalesceHit = (COALESCE_EN != 0) && pushLive && (countReg != '0)
                    && (youngEntry.pc == upd.updatePC_i)
                    && !(pop && (youngIdx == headReg));
  assign doWrite = pushLive && !coalesceHit && ((countReg != CNT_W'(DEPTH)) || pop);
  assign doDrop  = pushLive && !coalesceHit && !doWrite;

  always_comb begin
    countNext = countReg;
    case ({doWrite, pop})
      2'b10:   countNext = countReg + CNT_W'(1);
      2'b01:   countNext = countReg - CNT_W'(1);
      default: countNext = countReg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headReg      <= '0;
      tailReg      <= '0;
      countReg     <= '0;
      coalescedReg <= 1'b0;
      dropReg      <= 1'b0;
      dropCountReg <= '0;
    end else begin
      coalescedReg <= coalesceHit;
      dropReg      <= doDrop;
      if (doDrop && (dropCountReg != '1))
        dropCountReg <= dropCountReg + DROP_CNT_W'(1);
      // Flush wins over pointer motion; a same-cycle pop has already been taken by FS1.
      if (flush_i) begin
        headReg  <= '0;
        tailReg  <= '0;
        countReg <= '0;
      end else begin
        if (pop)
          headReg <= headReg + PTR_W'(1);
        if (doWrite)
          tailReg <= tailReg + PTR_W'(1);
        countReg <= countNext;
      end
    end
  end

  // Per-entry storage; entries are cleared on reset so head outputs read zero.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_t entryReg;
      logic   wrHere, coHere;

      assign wrHere = doWrite && (tailReg == PTR_W'(gi));
      assign coHere = coalesceHit && (youngIdx == PTR_W'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entryReg <= '0;
        end else if (wrHere) begin
          entryReg.pc       <= upd.updatePC_i;
          entryReg.npc      <= upd.updateNPC_i;
          entryReg.ctrlType <= upd.updateCtrlType_i;
          entryReg.dir      <= upd.updateDir_i;
          entryReg.counter  <= upd.updateCounter_i;
        end else if (coHere) begin
          entryReg.npc      <= upd.updateNPC_i;
          entryReg.ctrlType <= upd.updateCtrlType_i;
          entryReg.dir      <= upd.updateDir_i;
          entryReg.counter  <= upd.updateCounter_i;
        end
      end

      assign entryArr[gi] = entryReg;
    end
  endgenerate

  assign upd.updatePC_o       = headEntry.pc;
  assign upd.updateNPC_o      = headEntry.npc;
  assign upd.updateCtrlType_o = headEntry.ctrlType;
  assign upd.updateDir_o      = headEntry.dir;
  assign upd.updateCounter_o  = headEntry.counter;
  assign upd.updateEn_o       = (countReg != '0);

  assign occupancy_o = countReg;
  assign coalesced_o = coalescedReg;
  assign drop_o      = dropReg;
  assign dropCount_o = dropCountReg;
endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: directed vector table, async-reset sequence,
// then random traffic checked against a queue-level reference model.
module tb_bp_update_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int TYPE_W = 2;
  localparam int DCW   = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush_i;
  logic [CW-1:0]  occupancy_o;
  logic           coalesced_o, drop_o;
  logic [DCW-1:0] dropCount_o;

  bp_update_queue_if #(.PC_W(PC_W), .TYPE_W(TYPE_W)) upd();

  bp_update_queue #(
    .DEPTH(DEPTH), .PC_W(PC_W), .TYPE_W(TYPE_W), .COALESCE_EN(1), .DROP_CNT_W(DCW)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .upd(upd),
    .occupancy_o(occupancy_o), .coalesced_o(coalesced_o), .drop_o(drop_o),
    .dropCount_o(dropCount_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit rowBad;

  typedef struct {
    bit          fl, en;
    logic [31:0] pc;
    logic [1:0]  ctr;
    bit          rdy;
    int          occ;
    bit          eno;
    logic [31:0] pco;
    logic [1:0]  ctro;
    bit          co, dr;
    int          dc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, npc;
    logic [1:0]  typ;
    logic        dir;
    logic [1:0]  ctr;
  } ent_t;

  ent_t q[$];
  int   mDrop;
  bit   mCo, mDr;

  function automatic vec_t mk(bit fl, bit en, logic [31:0] pc, logic [1:0] ctr, bit rdy,
                              int occ, bit eno, logic [31:0] pco, logic [1:0] ctro,
                              bit co, bit dr, int dc);
    vec_t v;
    v.fl = fl; v.en = en; v.pc = pc; v.ctr = ctr; v.rdy = rdy;
    v.occ = occ; v.eno = eno; v.pco = pco; v.ctro = ctro; v.co = co; v.dr = dr; v.dc = dc;
    return v;
  endfunction

  task automatic cmp(string tag, int idx, string field, logic [63:0] act, logic [63:0] exp);
    if (act !== exp) begin
      $display("FAIL %s[%0d] %s: got %0h, want %0h", tag, idx, field, act, exp);
      rowBad = 1'b1;
    end
  endtask

  task automatic closeRow(string tag, int idx);
    vectors++;
    if (rowBad) miscompares++;
    $display("%s[%0d] occ=%0d en=%0b pc=%0h ctr=%0d co=%0b dr=%0b dc=%0d", tag, idx,
             occupancy_o, upd.updateEn_o, upd.updatePC_o, upd.updateCounter_o,
             coalesced_o, drop_o, dropCount_o);
  endtask

  task automatic drive(bit fl, bit en, logic [31:0] pc, logic [31:0] npc, logic [1:0] typ,
                       bit dir, logic [1:0] ctr, bit rdy);
    flush_i              = fl;
    upd.updateEn_i       = en;
    upd.updatePC_i       = pc;
    upd.updateNPC_i      = npc;
    upd.updateCtrlType_i = typ;
    upd.updateDir_i      = dir;
    upd.updateCounter_i  = ctr;
    upd.updateReady_i    = rdy;
  endtask

  // Reference: a plain FIFO of entries, one decision per cycle from the rule order.
  task automatic modelStep();
    bit   pop, pushNew;
    ent_t e;
    pop = (q.size() > 0) && upd.updateReady_i;
    pushNew = 1'b0;
    mCo = 1'b0;
    mDr = 1'b0;
    e.pc = upd.updatePC_i; e.npc = upd.updateNPC_i; e.typ = upd.updateCtrlType_i;
    e.dir = upd.updateDir_i; e.ctr = upd.updateCounter_i;
    if (flush_i) begin
      q.delete();
    end else begin
      if (upd.updateEn_i) begin
        if (q.size() > 0 && q[q.size()-1].pc == e.pc && !(pop && q.size() == 1)) begin
          q[q.size()-1] = e;
          mCo = 1'b1;
        end else if (q.size() < DEPTH || pop) begin
          pushNew = 1'b1;
        end else begin
          mDr = 1'b1;
          if (mDrop < 65535) mDrop++;
        end
      end
      if (pop) void'(q.pop_front());
      if (pushNew) q.push_back(e);
    end
  endtask

  task automatic checkModel(int idx);
    rowBad = 1'b0;
    cmp("rand", idx, "occupancy", 64'(occupancy_o), 64'(q.size()));
    cmp("rand", idx, "updateEn", 64'(upd.updateEn_o), 64'(q.size() > 0));
    if (q.size() > 0) begin
      cmp("rand", idx, "pc", 64'(upd.updatePC_o), 64'(q[0].pc));
      cmp("rand", idx, "npc", 64'(upd.updateNPC_o), 64'(q[0].npc));
      cmp("rand", idx, "type", 64'(upd.updateCtrlType_o), 64'(q[0].typ));
      cmp("rand", idx, "dir", 64'(upd.updateDir_o), 64'(q[0].dir));
      cmp("rand", idx, "counter", 64'(upd.updateCounter_o), 64'(q[0].ctr));
    end
    cmp("rand", idx, "coalesced", 64'(coalesced_o), 64'(mCo));
    cmp("rand", idx, "drop", 64'(drop_o), 64'(mDr));
    cmp("rand", idx, "dropCount", 64'(dropCount_o), 64'(mDrop));
    closeRow("rand", idx);
  endtask

  task automatic checkZero(string tag, int idx);
    rowBad = 1'b0;
    cmp(tag, idx, "occupancy", 64'(occupancy_o), 64'd0);
    cmp(tag, idx, "updateEn", 64'(upd.updateEn_o), 64'd0);
    cmp(tag, idx, "pc", 64'(upd.updatePC_o), 64'd0);
    cmp(tag, idx, "npc", 64'(upd.updateNPC_o), 64'd0);
    cmp(tag, idx, "type", 64'(upd.updateCtrlType_o), 64'd0);
    cmp(tag, idx, "dir", 64'(upd.updateDir_o), 64'd0);
    cmp(tag, idx, "counter", 64'(upd.updateCounter_o), 64'd0);
    cmp(tag, idx, "coalesced", 64'(coalesced_o), 64'd0);
    cmp(tag, idx, "drop", 64'(drop_o), 64'd0);
    cmp(tag, idx, "dropCount", 64'(dropCount_o), 64'd0);
    closeRow(tag, idx);
  endtask

  vec_t tbl[30];

  initial begin
    tbl[0]  = mk(0,1,32'h100,0,0, 1,1,32'h100,0,0,0,0);
    tbl[1]  = mk(0,1,32'h104,1,0, 2,1,32'h100,0,0,0,0);
    tbl[2]  = mk(0,1,32'h108,2,0, 3,1,32'h100,0,0,0,0);
    tbl[3]  = mk(0,0,32'h0,0,1,   2,1,32'h104,1,0,0,0);
    tbl[4]  = mk(0,0,32'h0,0,1,   1,1,32'h108,2,0,0,0);
    tbl[5]  = mk(0,0,32'h0,0,1,   0,0,32'h0,0,0,0,0);
    tbl[6]  = mk(0,1,32'h300,0,0, 1,1,32'h300,0,0,0,0);
    tbl[7]  = mk(0,1,32'h304,0,0, 2,1,32'h300,0,0,0,0);
    tbl[8]  = mk(0,1,32'h308,0,0, 3,1,32'h300,0,0,0,0);
    tbl[9]  = mk(0,1,32'h30C,0,0, 4,1,32'h300,0,0,0,0);
    tbl[10] = mk(0,1,32'h310,0,0, 4,1,32'h300,0,0,1,1);
    tbl[11] = mk(0,1,32'h314,2,1, 4,1,32'h304,0,0,0,1);
    tbl[12] = mk(0,1,32'h314,3,0, 4,1,32'h304,0,1,0,1);
    tbl[13] = mk(0,0,32'h0,0,1,   3,1,32'h308,0,0,0,1);
    tbl[14] = mk(0,0,32'h0,0,1,   2,1,32'h30C,0,0,0,1);
    tbl[15] = mk(0,0,32'h0,0,1,   1,1,32'h314,3,0,0,1);
    tbl[16] = mk(0,0,32'h0,0,1,   0,0,32'h0,0,0,0,1);
    tbl[17] = mk(0,1,32'h200,1,0, 1,1,32'h200,1,0,0,1);
    tbl[18] = mk(0,1,32'h200,3,0, 1,1,32'h200,3,1,0,1);
    tbl[19] = mk(0,0,32'h0,0,1,   0,0,32'h0,0,0,0,1);
    tbl[20] = mk(0,1,32'h200,1,0, 1,1,32'h200,1,0,0,1);
    tbl[21] = mk(0,1,32'h200,3,1, 1,1,32'h200,3,0,0,1);
    tbl[22] = mk(0,0,32'h0,0,1,   0,0,32'h0,0,0,0,1);
    tbl[23] = mk(0,1,32'h400,0,0, 1,1,32'h400,0,0,0,1);
    tbl[24] = mk(0,1,32'h404,0,0, 2,1,32'h400,0,0,0,1);
    tbl[25] = mk(0,1,32'h408,0,0, 3,1,32'h400,0,0,0,1);
    tbl[26] = mk(0,1,32'h40C,0,0, 4,1,32'h400,0,0,0,1);
    tbl[27] = mk(1,1,32'h410,0,0, 0,0,32'h0,0,0,0,1);
    tbl[28] = mk(0,1,32'h500,0,0, 1,1,32'h500,0,0,0,1);
    tbl[29] = mk(1,1,32'h504,0,1, 0,0,32'h0,0,0,0,1);

    reset = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkZero("reset", 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].fl, tbl[i].en, tbl[i].pc, tbl[i].pc + 32'h40, 2'd1, tbl[i].ctr[1],
            tbl[i].ctr, tbl[i].rdy);
      @(posedge clk);
      #1;
      rowBad = 1'b0;
      cmp("table", i, "occupancy", 64'(occupancy_o), 64'(tbl[i].occ));
      cmp("table", i, "updateEn", 64'(upd.updateEn_o), 64'(tbl[i].eno));
      if (tbl[i].eno) begin
        cmp("table", i, "pc", 64'(upd.updatePC_o), 64'(tbl[i].pco));
        cmp("table", i, "counter", 64'(upd.updateCounter_o), 64'(tbl[i].ctro));
      end
      cmp("table", i, "coalesced", 64'(coalesced_o), 64'(tbl[i].co));
      cmp("table", i, "drop", 64'(drop_o), 64'(tbl[i].dr));
      cmp("table", i, "dropCount", 64'(dropCount_o), 64'(tbl[i].dc));
      closeRow("table", i);
    end

    // Two entries queued with a nonzero drop count, then reset between clock edges.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 32'h700 + 32'(4 * i), 32'h740, 2'd2, 1'b1, 2'd2, 1'b0);
      @(posedge clk);
      #1;
      rowBad = 1'b0;
      cmp("areset", i, "occupancy", 64'(occupancy_o), 64'(i + 1));
      cmp("areset", i, "pc", 64'(upd.updatePC_o), 64'h700);
      closeRow("areset", i);
    end
    drive(0, 0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkZero("areset", 2);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    mDrop = 0;

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 70,
            32'h600 + 32'(4 * $urandom_range(0, 2)),
            $urandom,
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 40);
      @(posedge clk);
      modelStep();
      #1;
      checkModel(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
